operand_capture: RTL and testbench

Input-conditioning stage that sits directly upstream of the calculator ALU. It synchronizes and debounces the raw operand sign/magnitude switches and the add/subtract push-buttons, then converts each operand from sign-magnitude to 4-bit two's complement. On each button press it issues one captured operation to the ALU over a valid/ready handshake, so a held or bouncing button never produces duplicate operations.

---
 rtl/operand_capture_if.sv | 21 ++
 rtl/operand_capture.sv | 161 ++++++++++++++++
 tb/tb_operand_capture.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/operand_capture_if.sv
// Captured-operation bus between operand_capture (master) and the ALU (slave).
// Handshake: a transfer happens on a rising clk edge where op_valid && op_ready; master holds all fields stable while op_valid && !op_ready.
interface operand_capture_if;
    logic       op_valid;
    logic       op_ready;
    logic [3:0] a_val;
    logic [3:0] b_val;
    logic [1:0] mode;
    logic       aSign_out;
    logic       bSign_out;

    modport master (
        output op_valid, a_val, b_val, mode, aSign_out, bSign_out,
        input  op_ready
    );

    modport slave (
        input  op_valid, a_val, b_val, mode, aSign_out, bSign_out,
        output op_ready
    );
endinterface

// File: rtl/operand_capture.sv
// Synchronizes/debounces operand switches and add/sub buttons, converts sign-magnitude to two's complement,
// and issues one operation per button press. Define OPCAP_DEBOUNCE_EN to include the debouncers.
module operand_capture #(
    parameter int DB_CYCLES = 16,
    parameter int DB_W      = 5
) (
    input  logic               clk,
    input  logic               ar,
    input  logic               aSign,
    input  logic               a2,
    input  logic               a1,
    input  logic               a0,
    input  logic               bSign,
    input  logic               b2,
    input  logic               b1,
    input  logic               b0,
    input  logic               switchAdd,
    input  logic               switchSub,
    operand_capture_if.master  bus,
    output logic [1:0]         o_dbg_state
);
    localparam int N      = 10;
    localparam int I_ASGN = 3;
    localparam int I_BSGN = 7;
    localparam int I_ADD  = 8;
    localparam int I_SUB  = 9;

    if (DB_CYCLES < 2 || (2 ** DB_W) <= DB_CYCLES) begin : g_bad_cfg
        $error("operand_capture: need DB_CYCLES >= 2 and 2**DB_W > DB_CYCLES");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_VALID   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   w_raw;
    logic [N-1:0]   r_sync1;
    logic [N-1:0]   r_sync2;
    logic [N-1:0]   w_db;
    logic [1:0]     r_btn_prev;
    logic           w_add_rise;
    logic           w_sub_rise;
    logic           w_add_ok;
    logic           w_sub_ok;
    logic           w_capture;
    logic [3:0]     r_a_val;
    logic [3:0]     r_b_val;
    logic [1:0]     r_mode;
    logic           r_a_sign;
    logic           r_b_sign;

    assign w_raw = {switchSub, switchAdd, bSign, b2, b1, b0, aSign, a2, a1, a0};

    always_ff @(posedge clk or posedge ar) begin
        if (ar) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

`ifdef OPCAP_DEBOUNCE_EN
    logic [N-1:0]    r_db;
    logic [DB_W-1:0] r_cnt [N];

    // The counter only runs while the synchronized input disagrees with the output, so any glitch restarts it.
    always_ff @(posedge clk or posedge ar) begin
        if (ar) begin
            r_db <= '0;
            for (int i = 0; i < N; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
                    r_db[i]  <= ~r_db[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_db = r_db;
`else
    assign w_db = r_sync2;
`endif

    always_ff @(posedge clk or posedge ar) begin
        if (ar) r_btn_prev <= '0;
        else    r_btn_prev <= {w_db[I_SUB], w_db[I_ADD]};
    end

    assign w_add_rise = w_db[I_ADD] & ~r_btn_prev[0];
    assign w_sub_rise = w_db[I_SUB] & ~r_btn_prev[1];
    // A press only counts if the other button is not already held; a simultaneous rise goes to add.
    assign w_add_ok   = w_add_rise & ~(w_db[I_SUB] & ~w_sub_rise);
    assign w_sub_ok   = w_sub_rise & ~w_db[I_ADD];

    function automatic logic [3:0] to_twos(input logic s, input logic [2:0] m);
        logic [3:0] pos;
        pos = {1'b0, m};
        return s ? ((~pos) + 4'd1) : pos;
    endfunction

    always_ff @(posedge clk or posedge ar) begin
        if (ar) r_state <= S_IDLE;
        else    r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_add_ok || w_sub_ok) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_VALID;
                end
            end
            S_VALID: begin
                if (bus.op_ready) w_state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                if (!w_db[I_ADD] && !w_db[I_SUB]) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge ar) begin
        if (ar) begin
            r_a_val  <= 4'd0;
            r_b_val  <= 4'd0;
            r_mode   <= 2'b11;
            r_a_sign <= 1'b0;
            r_b_sign <= 1'b0;
        end else if (w_capture) begin
            r_a_val  <= to_twos(w_db[I_ASGN], w_db[2:0]);
            r_b_val  <= to_twos(w_db[I_BSGN], w_db[6:4]);
            r_mode   <= w_add_ok ? 2'b00 : 2'b01;
            r_a_sign <= w_db[I_ASGN];
            r_b_sign <= w_db[I_BSGN];
        end
    end

    assign bus.op_valid  = (r_state == S_VALID);
    assign bus.a_val     = r_a_val;
    assign bus.b_val     = r_b_val;
    assign bus.mode      = r_mode;
    assign bus.aSign_out = r_a_sign;
    assign bus.bSign_out = r_b_sign;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_operand_capture.sv
// Self-checking bench for operand_capture: vector table for conversions plus hand sequences for
// bounce, backpressure, simultaneous press and reset mid-operation; transfers checked by a scoreboard.
module tb_operand_capture;
    localparam int DB = 16;
`ifdef OPCAP_DEBOUNCE_EN
    localparam int LAT      = 2 + DB + 1;
    localparam int N_BOUNCE = 1;
`else
    localparam int LAT      = 3;
    localparam int N_BOUNCE = 6;
`endif

    logic clk = 1'b0;
    logic ar;
    logic aSign, a2, a1, a0, bSign, b2, b1, b0;
    logic switchAdd, switchSub;
    logic [1:0] dbg_state;

    operand_capture_if bus ();

    operand_capture #(.DB_CYCLES(DB), .DB_W(5)) dut (
        .clk         (clk),
        .ar          (ar),
        .aSign       (aSign),
        .a2          (a2),
        .a1          (a1),
        .a0          (a0),
        .bSign       (bSign),
        .b2          (b2),
        .b1          (b1),
        .b0          (b0),
        .switchAdd   (switchAdd),
        .switchSub   (switchSub),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int xfer_cnt = 0;
    logic [11:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] pack_exp(input logic [3:0] a, input logic [3:0] b,
                                            input logic [1:0] m, input logic as, input logic bs);
        return {a, b, m, as, bs};
    endfunction

    // scoreboard: a transfer is committed at the next rising edge when valid&&ready mid-cycle
    always @(negedge clk) begin
        if (!ar && bus.op_valid && bus.op_ready) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_transfer", 1, 0);
            end else begin
                check("transfer_data",
                      {20'd0, bus.a_val, bus.b_val, bus.mode, bus.aSign_out, bus.bSign_out},
                      {20'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_ops(input logic as, input logic [2:0] am, input logic bs, input logic [2:0] bm);
        aSign = as; {a2, a1, a0} = am;
        bSign = bs; {b2, b1, b0} = bm;
    endtask

    task automatic wait_valid(input string name, input int lat);
        int n;
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.op_valid) break;
        end
        check(name, n, lat);
        #1;
    endtask

    typedef struct {
        logic       as;
        logic [2:0] am;
        logic       bs;
        logic [2:0] bm;
        logic       sub;
        logic [3:0] ea;
        logic [3:0] eb;
        logic [1:0] em;
    } vec_t;

    vec_t tbl [5];
    int   base;

    initial begin
        tbl[0] = '{1'b0, 3'd5, 1'b0, 3'd2, 1'b0, 4'b0101, 4'b0010, 2'b00};
        tbl[1] = '{1'b1, 3'd7, 1'b1, 3'd0, 1'b1, 4'b1001, 4'b0000, 2'b01};
        tbl[2] = '{1'b0, 3'd7, 1'b1, 3'd3, 1'b0, 4'b0111, 4'b1101, 2'b00};
        tbl[3] = '{1'b1, 3'd1, 1'b0, 3'd0, 1'b1, 4'b1111, 4'b0000, 2'b01};
        tbl[4] = '{1'b1, 3'd4, 1'b1, 3'd5, 1'b0, 4'b1100, 4'b1011, 2'b00};

        // reset with random switches
        ar = 1'b1;
        set_ops(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        switchAdd = 1'b0; switchSub = 1'b0;
        bus.op_ready = 1'b0;
        tick(3);
        check("rst_valid", bus.op_valid, 0);
        check("rst_mode", bus.mode, 2'b11);
        ar = 1'b0;
        tick(LAT + 4);
        check("idle_valid", bus.op_valid, 0);
        check("idle_mode", bus.mode, 2'b11);
        check("idle_vals", {bus.a_val, bus.b_val, bus.aSign_out, bus.bSign_out}, 0);
        check("idle_state", dbg_state, 0);

        // conversion table
        bus.op_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_ops(tbl[i].as, tbl[i].am, tbl[i].bs, tbl[i].bm);
            tick(LAT + 4);
            exp_q.push_back(pack_exp(tbl[i].ea, tbl[i].eb, tbl[i].em, tbl[i].as, tbl[i].bs));
            if (tbl[i].sub) switchSub = 1'b1;
            else            switchAdd = 1'b1;
            wait_valid($sformatf("latency_%0d", i), LAT);
            check($sformatf("a_val_%0d", i), bus.a_val, tbl[i].ea);
            check($sformatf("b_val_%0d", i), bus.b_val, tbl[i].eb);
            check($sformatf("mode_%0d", i), bus.mode, tbl[i].em);
            check($sformatf("signs_%0d", i), {bus.aSign_out, bus.bSign_out}, {tbl[i].as, tbl[i].bs});
            tick(2);
            check($sformatf("valid_drop_%0d", i), bus.op_valid, 0);
            switchAdd = 1'b0; switchSub = 1'b0;
            tick(LAT + 4);
        end

        // bouncing add button
        set_ops(1'b0, 3'd1, 1'b0, 3'd1);
        tick(LAT + 4);
        base = xfer_cnt;
        for (int k = 0; k < N_BOUNCE; k++) exp_q.push_back(pack_exp(4'b0001, 4'b0001, 2'b00, 1'b0, 1'b0));
        for (int k = 0; k < 10; k++) begin
            switchAdd = (k % 2 == 0);
            tick(3);
        end
        switchAdd = 1'b1;
        wait_valid("bounce_latency", LAT);
        tick(2);
        check("bounce_count", xfer_cnt - base, N_BOUNCE);
        switchAdd = 1'b0;
        tick(LAT + 4);

        // backpressure: later presses and switch changes are ignored while valid
        bus.op_ready = 1'b0;
        set_ops(1'b0, 3'd3, 1'b0, 3'd1);
        tick(LAT + 4);
        base = xfer_cnt;
        switchAdd = 1'b1;
        wait_valid("bp_latency", LAT);
        set_ops(1'b1, 3'd6, 1'b0, 3'd1);
        switchSub = 1'b1;
        tick(LAT + 10);
        check("bp_hold_valid", bus.op_valid, 1);
        check("bp_hold_a", bus.a_val, 4'b0011);
        check("bp_hold_mode", bus.mode, 2'b00);
        check("bp_hold_asign", bus.aSign_out, 0);
        exp_q.push_back(pack_exp(4'b0011, 4'b0001, 2'b00, 1'b0, 1'b0));
        bus.op_ready = 1'b1;
        tick(2);
        check("bp_one_xfer", xfer_cnt - base, 1);
        tick(LAT + 6);
        check("bp_no_revalid", bus.op_valid, 0);
        check("bp_release_state", dbg_state, 2);
        switchAdd = 1'b0; switchSub = 1'b0;
        tick(LAT + 4);
        exp_q.push_back(pack_exp(4'b1010, 4'b0001, 2'b01, 1'b1, 1'b0));
        switchSub = 1'b1;
        wait_valid("bp_second_latency", LAT);
        check("bp_second_a", bus.a_val, 4'b1010);
        tick(2);
        check("bp_two_xfers", xfer_cnt - base, 2);
        switchSub = 1'b0;
        tick(LAT + 4);

        // simultaneous press
        set_ops(1'b0, 3'd2, 1'b0, 3'd3);
        tick(LAT + 4);
        exp_q.push_back(pack_exp(4'b0010, 4'b0011, 2'b00, 1'b0, 1'b0));
        switchAdd = 1'b1; switchSub = 1'b1;
        wait_valid("simul_latency", LAT);
        check("simul_mode", bus.mode, 2'b00);
        tick(2);
        switchAdd = 1'b0; switchSub = 1'b0;
        tick(LAT + 4);

        // reset during VALID, button held through reset release
        bus.op_ready = 1'b0;
        set_ops(1'b0, 3'd4, 1'b1, 3'd1);
        tick(LAT + 4);
        switchAdd = 1'b1;
        wait_valid("rstmid_latency", LAT);
        base = xfer_cnt;
        ar = 1'b1;
        #1;
        check("rstmid_valid", bus.op_valid, 0);
        check("rstmid_mode", bus.mode, 2'b11);
        check("rstmid_a", bus.a_val, 0);
        tick(3);
        exp_q.push_back(pack_exp(4'b0100, 4'b1111, 2'b00, 1'b0, 1'b1));
        ar = 1'b0;
        wait_valid("held_through_reset", LAT);
        check("rstmid_no_xfer", xfer_cnt - base, 0);
        bus.op_ready = 1'b1;
        tick(2);
        check("rstmid_fresh_xfer", xfer_cnt - base, 1);
        switchAdd = 1'b0;
        tick(LAT + 4);

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
